// File: rtl/mult_feeder.sv
// Issue stage for the 8x8 ROM multiplier: operand FIFO, one-at-a-time START/DONE sequencing
// and a valid/ready result register. Optional WAIT timeout enabled by MULFEED_TIMEOUT_EN.
module mult_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [7:0]               IN_A,
  input  logic [7:0]               IN_B,
  output logic                     MUL_START,
  output logic [7:0]               MUL_A,
  output logic [7:0]               MUL_B,
  input  logic                     MUL_DONE,
  input  logic [15:0]              MUL_RES,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [15:0]              OUT_RES,
  output logic                     OUT_ERR,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  logic [7:0]    mul_a_r;
  logic [7:0]    mul_b_r;
  logic          out_valid_r;
  logic [15:0]   out_res_r;
  logic          out_err_r;

  logic in_ready_s;
  logic push_s;
  logic pop_s;
  logic out_free_s;

`ifdef MULFEED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt_r;
`endif

  // Ready depends only on registered occupancy, so a full FIFO never accepts even on a pop edge.
  assign in_ready_s = (count_r < CW'(DEPTH));
  assign push_s     = IN_VALID && in_ready_s;
  assign out_free_s = !out_valid_r || OUT_READY;
  assign pop_s      = (state_r == IDLE) && (count_r != {CW{1'b0}}) && out_free_s;

  assign IN_READY  = in_ready_s;
  assign COUNT     = count_r;
  assign MUL_START = (state_r == ISSUE);
  assign MUL_A     = mul_a_r;
  assign MUL_B     = mul_b_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_RES   = out_res_r;
`ifdef MULFEED_TIMEOUT_EN
  assign OUT_ERR   = out_err_r;
`else
  assign OUT_ERR   = 1'b0;
`endif

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {IN_A, IN_B};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM and result register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      mul_a_r     <= 8'd0;
      mul_b_r     <= 8'd0;
      out_valid_r <= 1'b0;
      out_res_r   <= 16'd0;
      out_err_r   <= 1'b0;
`ifdef MULFEED_TIMEOUT_EN
      tmo_cnt_r   <= {TW{1'b0}};
`endif
    end else begin
      // A completed handshake frees the register; a capture below may refill it on the same edge.
      if (out_valid_r && OUT_READY) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            mul_a_r <= mem_r[rd_ptr_r][15:8];
            mul_b_r <= mem_r[rd_ptr_r][7:0];
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
`ifdef MULFEED_TIMEOUT_EN
          tmo_cnt_r <= {TW{1'b0}};
`endif
        end
        WAIT: begin
          if (MUL_DONE) begin
            out_res_r   <= MUL_RES;
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
`ifdef MULFEED_TIMEOUT_EN
          end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
            out_res_r   <= 16'hFFFF;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r   <= tmo_cnt_r + TW'(1);
            state_r     <= WAIT;
          end
`else
          end else begin
            state_r     <= WAIT;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_feeder.sv
// Randomised self-checking bench for mult_feeder with a latency-configurable multiplier model
// and a transaction-level scoreboard (operand queue -> product queue, push order).
module tb_mult_feeder;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_A;
  logic [7:0]  IN_B;
  logic        MUL_START;
  logic [7:0]  MUL_A;
  logic [7:0]  MUL_B;
  logic        MUL_DONE;
  logic [15:0] MUL_RES;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_RES;
  logic        OUT_ERR;
  logic [2:0]  COUNT;

  mult_feeder #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .MUL_START(MUL_START), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_DONE(MUL_DONE), .MUL_RES(MUL_RES),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RES(OUT_RES), .OUT_ERR(OUT_ERR),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Scoreboard: accepted operand pairs awaiting issue, and products issued awaiting output.
  logic [15:0] issue_q[$];
  logic [15:0] result_q[$];
  logic [15:0] out_log[$];
  int pushes_n = 0;
  int starts_n = 0;
  int cyc = 0;
  int push_cyc_last = 0;
  int start_cyc_last = 0;
  int first_valid_cyc = -1;
  logic [7:0] start_a_last = 8'd0;
  logic [7:0] start_b_last = 8'd0;

  // Knobs for the environment.
  int rdy_mode = 1;
  bit mul_en   = 1'b1;
  int mul_lat  = 4;
  bit lat_rand = 1'b0;
  bit tmo_mode = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Multiplier model: latches operands on START, pulses DONE with the product L cycles later.
  logic [15:0] ma, mb;
  int mcnt;
  initial begin
    MUL_DONE = 1'b0;
    MUL_RES  = 16'd0;
    ma = 16'd0; mb = 16'd0; mcnt = 0;
    forever begin
      @(negedge CLK);
      if (MUL_START === 1'b1) begin
        ma = {8'd0, MUL_A};
        mb = {8'd0, MUL_B};
        mcnt = lat_rand ? int'($urandom_range(1, 6)) : mul_lat;
      end
      @(posedge CLK);
      #2;
      if (mcnt > 0) begin
        mcnt--;
        MUL_DONE = (mcnt == 0) && mul_en;
      end else begin
        MUL_DONE = 1'b0;
      end
      MUL_RES = MUL_DONE ? ma * mb : 16'($urandom);
    end
  end

  // Consumer ready driver.
  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      OUT_READY = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Compare process: every cycle, against the scoreboard.
  logic        prev_start = 1'b0;
  logic        prev_hold  = 1'b0;
  logic [15:0] prev_res   = 16'd0;
  logic        prev_err   = 1'b0;
  logic [15:0] op;
  logic [15:0] r;
  int pa, pb;
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        issue_q.delete();
        result_q.delete();
        pushes_n = 0;
        starts_n = 0;
        prev_start = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (MUL_START) begin
          check("start_consecutive", prev_start, 0);
          check("one_outstanding", result_q.size() <= 1, 1);
          if (issue_q.size() == 0) begin
            check("start_without_entry", 1, 0);
          end else begin
            op = issue_q.pop_front();
            check("mul_a", MUL_A, op[15:8]);
            check("mul_b", MUL_B, op[7:0]);
            pa = op[15:8];
            pb = op[7:0];
            result_q.push_back(16'(pa * pb));
          end
          starts_n++;
          start_cyc_last = cyc;
          start_a_last = MUL_A;
          start_b_last = MUL_B;
        end
        prev_start = MUL_START;
        check("count", COUNT, pushes_n - starts_n);
        check("in_ready", IN_READY, (pushes_n - starts_n) < DEPTH);
        if (prev_hold) begin
          check("hold_valid", OUT_VALID, 1);
          check("hold_res", OUT_RES, prev_res);
          check("hold_err", OUT_ERR, prev_err);
        end
        if (OUT_VALID && result_q.size() == 0) check("spurious_valid", 1, 0);
        if (OUT_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (OUT_VALID && OUT_READY && result_q.size() != 0) begin
          r = result_q.pop_front();
          check("out_res", OUT_RES, tmo_mode ? 16'hFFFF : r);
          check("out_err", OUT_ERR, tmo_mode ? 1 : 0);
          out_log.push_back(OUT_RES);
        end
        prev_hold = OUT_VALID && !OUT_READY;
        prev_res  = OUT_RES;
        prev_err  = OUT_ERR;
        if (IN_VALID && IN_READY) begin
          issue_q.push_back({IN_A, IN_B});
          pushes_n++;
          push_cyc_last = cyc;
        end
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    IN_VALID = 1'b1;
    IN_A = a;
    IN_B = b;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge CLK);
      acc = IN_READY;
    end
    if (!acc) check("push_accept_timeout", 0, 1);
    @(posedge CLK);
    #2;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 3000 && !idle; k++) begin
      @(negedge CLK);
      #1;
      idle = (issue_q.size() == 0) && (result_q.size() == 0) && !OUT_VALID && !MUL_START;
    end
    if (!idle) check("drain_timeout", 0, 1);
    @(posedge CLK);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  int base;
  int s0;
  bit found;
  logic [7:0] fa[6];
  logic [7:0] fb[6];

  initial begin
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_A = 8'd0;
    IN_B = 8'd0;
    cycles(2);
    check("rst_in_ready", IN_READY, 1);
    check("rst_count", COUNT, 0);
    check("rst_mul_start", MUL_START, 0);
    check("rst_mul_a", MUL_A, 0);
    check("rst_mul_b", MUL_B, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_res", OUT_RES, 0);
    check("rst_out_err", OUT_ERR, 0);
    RST = 1'b0;
    cycles(2);

    // Single op, 4-cycle multiplier.
    first_valid_cyc = -1;
    base = out_log.size();
    push(8'd200, 8'd150);
    wait_idle();
    check("single_starts", starts_n, 1);
    check("single_a", start_a_last, 200);
    check("single_b", start_b_last, 150);
    check("single_start_lat", start_cyc_last - push_cyc_last, 2);
    check("single_out_lat", first_valid_cyc - push_cyc_last, 7);
    check("single_nout", out_log.size() - base, 1);
    if (out_log.size() > base) check("single_res", out_log[base], 16'd30000);

    // Fill with the consumer stalled, then hold the output for 10 cycles.
    fa = '{8'hFF, 8'h00, 8'h01, 8'h12, 8'hAB, 8'h3C};
    fb = '{8'hFF, 8'h07, 8'h01, 8'h34, 8'hCD, 8'h5A};
    rdy_mode = 0;
    cycles(1);
    base = out_log.size();
    for (int i = 0; i < 5; i++) push(fa[i], fb[i]);
    cycles(6);
    s0 = starts_n;
    cycles(10);
    check("held_no_start", starts_n - s0, 0);
    check("held_valid", OUT_VALID, 1);
    check("full_in_ready", IN_READY, 0);
    check("full_count", COUNT, 4);
    rdy_mode = 1;
    push(fa[5], fb[5]);
    wait_idle();
    check("fill_nout", out_log.size() - base, 6);
    if (out_log.size() >= base + 3) begin
      check("fill_res0", out_log[base], 16'hFE01);
      check("fill_res1", out_log[base + 1], 16'h0000);
      check("fill_res2", out_log[base + 2], 16'h0001);
    end

    // Reset while waiting on the multiplier; DONE arrives after reset.
    mul_lat = 6;
    push(8'd9, 8'd9);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge CLK);
      #1;
      found = MUL_START;
    end
    check("rst_mid_start_seen", found, 1);
    @(posedge CLK);
    cycles(1);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    cycles(8);
    check("rst_mid_valid", OUT_VALID, 0);
    check("rst_mid_count", COUNT, 0);
    mul_lat = 4;

    // Random traffic with random ready and multiplier latency.
    rdy_mode = 2;
    lat_rand = 1'b1;
    base = out_log.size();
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom_range(0, 255)), (i % 7 == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      cycles(int'($urandom_range(0, 3)));
    end
    wait_idle();
    check("rand_nout", out_log.size() - base, 40);
    lat_rand = 1'b0;
    rdy_mode = 1;

`ifdef MULFEED_TIMEOUT_EN
    // Multiplier never answers: error result after TIMEOUT cycles in WAIT.
    mul_en = 1'b0;
    tmo_mode = 1'b1;
    first_valid_cyc = -1;
    base = out_log.size();
    push(8'd3, 8'd4);
    wait_idle();
    check("tmo_lat", first_valid_cyc - start_cyc_last, TMO + 1);
    check("tmo_nout", out_log.size() - base, 1);
    if (out_log.size() > base) check("tmo_res", out_log[base], 16'hFFFF);
    tmo_mode = 1'b0;
    mul_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
